// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: bus widths, enable levels,
// ALU operator/category codes and the divider FSM state type.
package execute_stage_pkg;

  localparam int REGS_DATA_W    = 32;
  localparam int REGS_ADDR_W    = 5;
  localparam int ALU_OPERATOR_W = 8;
  localparam int ALU_CATEGORY_W = 3;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // ALU categories
  localparam logic [ALU_CATEGORY_W-1:0] CAT_NOP   = 3'd0;
  localparam logic [ALU_CATEGORY_W-1:0] CAT_LOGIC = 3'd1;
  localparam logic [ALU_CATEGORY_W-1:0] CAT_SHIFT = 3'd2;
  localparam logic [ALU_CATEGORY_W-1:0] CAT_ARITH = 3'd3;
  localparam logic [ALU_CATEGORY_W-1:0] CAT_DIV   = 3'd4;

  // ALU operators
  localparam logic [ALU_OPERATOR_W-1:0] OP_NOP  = 8'h00;
  localparam logic [ALU_OPERATOR_W-1:0] OP_AND  = 8'h24;
  localparam logic [ALU_OPERATOR_W-1:0] OP_OR   = 8'h25;
  localparam logic [ALU_OPERATOR_W-1:0] OP_XOR  = 8'h26;
  localparam logic [ALU_OPERATOR_W-1:0] OP_NOR  = 8'h27;
  localparam logic [ALU_OPERATOR_W-1:0] OP_SLL  = 8'h7C;
  localparam logic [ALU_OPERATOR_W-1:0] OP_SRL  = 8'h02;
  localparam logic [ALU_OPERATOR_W-1:0] OP_SRA  = 8'h03;
  localparam logic [ALU_OPERATOR_W-1:0] OP_ADDU = 8'h21;
  localparam logic [ALU_OPERATOR_W-1:0] OP_SUBU = 8'h23;
  localparam logic [ALU_OPERATOR_W-1:0] OP_SLT  = 8'h2A;
  localparam logic [ALU_OPERATOR_W-1:0] OP_SLTU = 8'h2B;
  localparam logic [ALU_OPERATOR_W-1:0] OP_DIV  = 8'h1A;
  localparam logic [ALU_OPERATOR_W-1:0] OP_DIVU = 8'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
//   master: upstream side, drives the ex_* request and annul, sees results.
//   slave : the execute stage, consumes ex_* and drives mem_* and stall_request.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic                      annul;
  logic [ALU_OPERATOR_W-1:0] ex_operator;
  logic [ALU_CATEGORY_W-1:0] ex_category;
  logic [REGS_DATA_W-1:0]    ex_operand1;
  logic [REGS_DATA_W-1:0]    ex_operand2;
  logic [REGS_ADDR_W-1:0]    ex_write_addr;
  logic                      ex_write_enable;

  logic [REGS_ADDR_W-1:0]    mem_write_addr;
  logic                      mem_write_enable;
  logic [REGS_DATA_W-1:0]    mem_write_data;
  logic                      mem_hilo_write_enable;
  logic [REGS_DATA_W-1:0]    mem_hi;
  logic [REGS_DATA_W-1:0]    mem_lo;
  logic                      stall_request;

  modport master (
    output annul, ex_operator, ex_category, ex_operand1, ex_operand2,
           ex_write_addr, ex_write_enable,
    input  mem_write_addr, mem_write_enable, mem_write_data,
           mem_hilo_write_enable, mem_hi, mem_lo, stall_request
  );

  modport slave (
    input  annul, ex_operator, ex_category, ex_operand1, ex_operand2,
           ex_write_addr, ex_write_enable,
    output mem_write_addr, mem_write_enable, mem_write_data,
           mem_hilo_write_enable, mem_hi, mem_lo, stall_request
  );
endinterface

// File: rtl/execute_stage_divider.sv
// Multi-cycle restoring divider (signed/unsigned), one quotient bit per cycle.
// Ports:
//   clock, reset         - clock, async active-high reset
//   start, signed_div    - request a divide this cycle (sampled only in IDLE)
//   dividend, divisor    - operands, held stable by upstream while stalled
//   annul                - abort any divide, back to IDLE on next edge
//   done                 - registered one-cycle pulse in DONE
//   stall                - high in the accept cycle and all BUSY cycles
//   quotient, remainder  - registered results, valid while done is high
module divider
  import execute_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  annul,
  output logic                  done,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int CW = $clog2(DATA_WIDTH);

  div_state_t            state;
  logic [DATA_WIDTH-1:0] dvd;   // magnitude of dividend; quotient bits shift in at the LSB
  logic [DATA_WIDTH-1:0] dvs;
  logic [DATA_WIDTH-1:0] rem;
  logic                  neg_q;
  logic                  neg_r;
  logic [CW-1:0]         count;

  logic [DATA_WIDTH:0]   partial;
  logic [DATA_WIDTH+1:0] diff;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;

  // Restoring step: the partial remainder is always below the divisor, so the
  // trial subtraction result fits in DATA_WIDTH bits whenever it does not borrow.
  always_comb begin
    partial  = {rem, dvd[DATA_WIDTH-1]};
    diff     = {1'b0, partial} - {2'b00, dvs};
    q_bit    = ~diff[DATA_WIDTH+1];
    rem_next = q_bit ? diff[DATA_WIDTH-1:0] : partial[DATA_WIDTH-1:0];
    quo_next = {dvd[DATA_WIDTH-2:0], q_bit};
  end

  assign stall = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= DIV_IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (annul) begin
      state <= DIV_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '0;
              remainder <= '0;
              done      <= 1'b1;
              state     <= DIV_DONE;
            end else begin
              dvd   <= (signed_div && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
              dvs   <= (signed_div && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
              rem   <= '0;
              neg_q <= signed_div && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
              neg_r <= signed_div && dividend[DATA_WIDTH-1];
              count <= '0;
              state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          dvd   <= quo_next;
          rem   <= rem_next;
          count <= count + 1'b1;
          if (count == CW'(DATA_WIDTH - 1)) begin
            quotient  <= neg_q ? -quo_next : quo_next;
            remainder <= neg_r ? -rem_next : rem_next;
            done      <= 1'b1;
            state     <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          done  <= 1'b0;
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: zero-latency LOGIC/SHIFT/ARITH ALU plus a multi-cycle divider
// that writes HI/LO and stalls upstream while it runs.
// Ports:
//   clock, reset - clock, async active-high reset (all outputs forced to 0)
//   bus          - execute_stage_if.slave: ex_* request in, mem_* results and
//                  stall_request out, annul (flush) in
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  logic [DATA_WIDTH-1:0] alu_result;
  logic [4:0]            shamt;
  logic                  div_start;
  logic                  div_done;
  logic                  div_stall;
  logic [DATA_WIDTH-1:0] div_quotient;
  logic [DATA_WIDTH-1:0] div_remainder;
  logic                  hilo_we;

  assign shamt = bus.ex_operand1[4:0];

  always_comb begin
    alu_result = '0;
    case (bus.ex_category)
      CAT_LOGIC: begin
        case (bus.ex_operator)
          OP_AND:  alu_result = bus.ex_operand1 & bus.ex_operand2;
          OP_OR:   alu_result = bus.ex_operand1 | bus.ex_operand2;
          OP_XOR:  alu_result = bus.ex_operand1 ^ bus.ex_operand2;
          OP_NOR:  alu_result = ~(bus.ex_operand1 | bus.ex_operand2);
          default: alu_result = '0;
        endcase
      end
      CAT_SHIFT: begin
        case (bus.ex_operator)
          OP_SLL:  alu_result = bus.ex_operand2 << shamt;
          OP_SRL:  alu_result = bus.ex_operand2 >> shamt;
          OP_SRA:  alu_result = $signed(bus.ex_operand2) >>> shamt;
          default: alu_result = '0;
        endcase
      end
      CAT_ARITH: begin
        case (bus.ex_operator)
          OP_ADDU: alu_result = bus.ex_operand1 + bus.ex_operand2;
          OP_SUBU: alu_result = bus.ex_operand1 - bus.ex_operand2;
          OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}},
                                 $signed(bus.ex_operand1) < $signed(bus.ex_operand2)};
          OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}},
                                 bus.ex_operand1 < bus.ex_operand2};
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign div_start = (bus.ex_category == CAT_DIV) &&
                     ((bus.ex_operator == OP_DIV) || (bus.ex_operator == OP_DIVU));

  divider #(.DATA_WIDTH(DATA_WIDTH)) u_divider (
    .clock      (clock),
    .reset      (reset),
    .start      (div_start),
    .signed_div (bus.ex_operator == OP_DIV),
    .dividend   (bus.ex_operand1),
    .divisor    (bus.ex_operand2),
    .annul      (bus.annul),
    .done       (div_done),
    .stall      (div_stall),
    .quotient   (div_quotient),
    .remainder  (div_remainder)
  );

  // Reset and annul gate the outputs combinationally so their effect is seen
  // in the same cycle rather than after the next edge.
  assign hilo_we = !reset && !bus.annul && div_done;

  assign bus.mem_write_addr        = reset ? '0 : bus.ex_write_addr;
  assign bus.mem_write_enable      = !reset && !bus.annul &&
                                     (bus.ex_category != CAT_DIV) && bus.ex_write_enable;
  assign bus.mem_write_data        = reset ? '0 : alu_result;
  assign bus.mem_hilo_write_enable = hilo_we;
  assign bus.mem_hi                = hilo_we ? div_remainder : '0;
  assign bus.mem_lo                = hilo_we ? div_quotient  : '0;
  assign bus.stall_request         = !reset && !bus.annul && div_stall;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  execute_stage_if bus();

  execute_stage #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
  } alu_exp_t;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  cat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  alu_exp_t    alu_q[$];
  logic [63:0] div_q[$];   // {hi, lo}

  task automatic drive(input logic [7:0] op, input logic [2:0] cat,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] addr, input logic we);
    bus.ex_operator     = op;
    bus.ex_category     = cat;
    bus.ex_operand1     = a;
    bus.ex_operand2     = b;
    bus.ex_write_addr   = addr;
    bus.ex_write_enable = we;
  endtask

  task automatic drive_nop();
    drive(OP_NOP, CAT_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [2:0] cat,
                                            input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (cat)
      CAT_LOGIC:
        case (op)
          OP_AND: return a & b;
          OP_OR:  return a | b;
          OP_XOR: return a ^ b;
          OP_NOR: return ~(a | b);
          default: return 32'h0;
        endcase
      CAT_SHIFT:
        case (op)
          OP_SLL: return b << a[4:0];
          OP_SRL: return b >> a[4:0];
          OP_SRA: return sb >>> a[4:0];
          default: return 32'h0;
        endcase
      CAT_ARITH:
        case (op)
          OP_ADDU: return a + b;
          OP_SUBU: return a - b;
          OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
          OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
          default: return 32'h0;
        endcase
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] div_model(input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'h0) return 64'h0;
    if (op == OP_DIVU) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  // Runs one divide to completion. pre=1 means the operands are already on the
  // bus (presented during the previous DONE cycle). chain=1 leaves the next
  // divide on the bus during DONE instead of a NOP.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit pre, input bit chain,
                         input logic [7:0] nop, input logic [31:0] na, input logic [31:0] nb);
    int stalls;
    bit got;
    int exp_stalls;
    logic [63:0] exp;
    @(negedge clock);
    if (!pre) drive(op, CAT_DIV, a, b, 5'd9, 1'b1);
    div_q.push_back(div_model(op, a, b));
    exp_stalls = (b == 32'h0) ? 1 : 33;
    #1;
    compared++;
    if (bus.stall_request !== 1'b1 || bus.mem_hilo_write_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL div_accept op=%h a=%h b=%h: stall=%b hilo_we=%b, required stall=1 hilo_we=0",
               op, a, b, bus.stall_request, bus.mem_hilo_write_enable);
    end
    compared++;
    if (bus.mem_write_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL div_no_gpr_write: mem_write_enable=%b, required 0", bus.mem_write_enable);
    end
    stalls = 1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (bus.mem_hilo_write_enable === 1'b1) begin
        got = 1;
        break;
      end
      if (bus.stall_request === 1'b1) stalls++;
    end
    exp = div_q.pop_front();
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL div_timeout op=%h a=%h b=%h: no hilo write within 40 cycles, required one",
               op, a, b);
      drive_nop();
      return;
    end
    if (stalls != exp_stalls) begin
      mismatched++;
      $display("FAIL div_stall_cycles op=%h a=%h b=%h: got %0d, required %0d",
               op, a, b, stalls, exp_stalls);
    end
    compared++;
    if ({bus.mem_hi, bus.mem_lo} !== exp) begin
      mismatched++;
      $display("FAIL div_result op=%h a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
               op, a, b, bus.mem_hi, bus.mem_lo, exp[63:32], exp[31:0]);
    end
    compared++;
    if (bus.stall_request !== 1'b0 || bus.mem_write_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL div_done_outputs: stall=%b we=%b, required 0 0",
               bus.stall_request, bus.mem_write_enable);
    end
    if (chain) begin
      drive(nop, CAT_DIV, na, nb, 5'd9, 1'b1);
      #1;
      compared++;
      if (bus.stall_request !== 1'b0) begin
        mismatched++;
        $display("FAIL done_no_accept: stall=%b, required 0", bus.stall_request);
      end
    end else begin
      drive_nop();
      @(negedge clock);
      #1;
      compared++;
      if (bus.mem_hilo_write_enable !== 1'b0 || bus.stall_request !== 1'b0) begin
        mismatched++;
        $display("FAIL done_pulse_width: hilo_we=%b stall=%b, required 0 0",
                 bus.mem_hilo_write_enable, bus.stall_request);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.annul = 1'b0;
    drive(OP_ADDU, CAT_ARITH, 32'd5, 32'd6, 5'd7, 1'b1);
    #1;
    compared++;
    if (bus.mem_write_data !== 32'h0 || bus.mem_write_addr !== 5'd0 ||
        bus.mem_write_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_gpr: data=%h addr=%h we=%b, required 0 0 0",
               bus.mem_write_data, bus.mem_write_addr, bus.mem_write_enable);
    end
    drive(OP_DIV, CAT_DIV, 32'd7, 32'd2, 5'd1, 1'b1);
    @(negedge clock);
    #1;
    compared++;
    if (bus.stall_request !== 1'b0 || bus.mem_hilo_write_enable !== 1'b0 ||
        bus.mem_hi !== 32'h0 || bus.mem_lo !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_div: stall=%b hilo_we=%b hi=%h lo=%h, required all 0",
               bus.stall_request, bus.mem_hilo_write_enable, bus.mem_hi, bus.mem_lo);
    end
    drive_nop();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_alu();
    vec_t v[$];
    alu_exp_t e;
    v.push_back('{OP_ADDU, CAT_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    v.push_back('{OP_SRA,  CAT_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000});
    v.push_back('{OP_SLT,  CAT_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    v.push_back('{OP_SLTU, CAT_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    v.push_back('{OP_SUBU, CAT_ARITH, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
    v.push_back('{OP_AND,  CAT_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
    v.push_back('{OP_OR,   CAT_LOGIC, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0});
    v.push_back('{OP_XOR,  CAT_LOGIC, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0});
    v.push_back('{OP_NOR,  CAT_LOGIC, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F});
    v.push_back('{OP_SLL,  CAT_SHIFT, 32'h0000_003F, 32'h0000_0001, 32'h8000_0000});
    v.push_back('{OP_SRL,  CAT_SHIFT, 32'h0000_001F, 32'h8000_0000, 32'h0000_0001});
    v.push_back('{OP_ADDU, CAT_NOP,   32'h1234_5678, 32'h1111_1111, 32'h0000_0000});
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ops [4];
      ops[0] = OP_ADDU; ops[1] = OP_SRA; ops[2] = OP_SLT; ops[3] = OP_XOR;
      v.push_back('{ops[i % 4], (i % 4 == 1) ? CAT_SHIFT : ((i % 4 == 3) ? CAT_LOGIC : CAT_ARITH),
                    $urandom, $urandom, 32'h0});
    end
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clock);
      drive(v[i].op, v[i].cat, v[i].a, v[i].b, 5'(i + 1), (i % 3) != 2);
      e.data = (i < 12) ? v[i].exp : alu_model(v[i].op, v[i].cat, v[i].a, v[i].b);
      e.addr = 5'(i + 1);
      e.we   = (i % 3) != 2;
      alu_q.push_back(e);
      #1;
      e = alu_q.pop_front();
      compared++;
      if (bus.mem_write_data !== e.data) begin
        mismatched++;
        $display("FAIL alu_data[%0d] op=%h a=%h b=%h: got %h, required %h",
                 i, v[i].op, v[i].a, v[i].b, bus.mem_write_data, e.data);
      end
      compared++;
      if (bus.mem_write_enable !== e.we || bus.mem_write_addr !== e.addr ||
          bus.stall_request !== 1'b0) begin
        mismatched++;
        $display("FAIL alu_ctrl[%0d]: we=%b addr=%h stall=%b, required we=%b addr=%h stall=0",
                 i, bus.mem_write_enable, bus.mem_write_addr, bus.stall_request, e.we, e.addr);
      end
    end
    drive_nop();
  endtask

  task automatic test_div();
    run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2,        0, 0, OP_NOP, 0, 0);
    run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, OP_NOP, 0, 0);
    run_div(OP_DIVU, 32'd100,       32'd0,        0, 0, OP_NOP, 0, 0);
    run_div(OP_DIV,  32'd7,         32'hFFFF_FFFE, 0, 0, OP_NOP, 0, 0);
    run_div(OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 0, OP_NOP, 0, 0);
    run_div(OP_DIVU, $urandom,      32'($urandom_range(1, 1000)), 0, 0, OP_NOP, 0, 0);
    run_div(OP_DIV,  $urandom,      32'($urandom_range(3, 60)) - 32'd30, 0, 0, OP_NOP, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_div(OP_DIVU, 32'd50, 32'd7, 0, 1, OP_DIV, 32'd20, 32'hFFFF_FFFD);
    run_div(OP_DIV, 32'd20, 32'hFFFF_FFFD, 1, 0, OP_NOP, 0, 0);
  endtask

  task automatic test_annul();
    int hilo_seen;
    @(negedge clock);
    drive(OP_ADDU, CAT_ARITH, 32'd1, 32'd1, 5'd4, 1'b1);
    bus.annul = 1'b1;
    #1;
    compared++;
    if (bus.mem_write_enable !== 1'b0 || bus.mem_write_data !== 32'd2) begin
      mismatched++;
      $display("FAIL annul_alu: we=%b data=%h, required we=0 data=00000002",
               bus.mem_write_enable, bus.mem_write_data);
    end
    bus.annul = 1'b0;
    @(negedge clock);
    drive(OP_DIVU, CAT_DIV, 32'hFFFF_FFFF, 32'd16, 5'd2, 1'b1);
    hilo_seen = 0;
    repeat (10) begin
      @(negedge clock);
      #1;
      if (bus.mem_hilo_write_enable === 1'b1) hilo_seen++;
    end
    bus.annul = 1'b1;
    #1;
    compared++;
    if (bus.stall_request !== 1'b0 || bus.mem_hilo_write_enable !== 1'b0 ||
        bus.mem_write_enable !== 1'b0 || hilo_seen != 0) begin
      mismatched++;
      $display("FAIL annul_busy: stall=%b hilo_we=%b we=%b early_hilo=%0d, required all 0",
               bus.stall_request, bus.mem_hilo_write_enable, bus.mem_write_enable, hilo_seen);
    end
    @(negedge clock);
    bus.annul = 1'b0;
    drive_nop();
    #1;
    compared++;
    if (bus.stall_request !== 1'b0 || bus.mem_hilo_write_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL annul_idle: stall=%b hilo_we=%b, required 0 0",
               bus.stall_request, bus.mem_hilo_write_enable);
    end
    run_div(OP_DIVU, 32'd9, 32'd3, 0, 0, OP_NOP, 0, 0);
  endtask

  task automatic test_reset_mid_divide();
    int hilo_seen;
    @(negedge clock);
    drive(OP_DIV, CAT_DIV, 32'd1000, 32'd7, 5'd3, 1'b1);
    repeat (20) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (bus.stall_request !== 1'b0 || bus.mem_hilo_write_enable !== 1'b0 ||
        bus.mem_write_enable !== 1'b0 || bus.mem_write_data !== 32'h0 ||
        bus.mem_write_addr !== 5'd0 || bus.mem_hi !== 32'h0 || bus.mem_lo !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_async: stall=%b hilo_we=%b we=%b data=%h addr=%h hi=%h lo=%h, required all 0",
               bus.stall_request, bus.mem_hilo_write_enable, bus.mem_write_enable,
               bus.mem_write_data, bus.mem_write_addr, bus.mem_hi, bus.mem_lo);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(OP_ADDU, CAT_ARITH, 32'd2, 32'd3, 5'd3, 1'b1);
    #1;
    compared++;
    if (bus.mem_write_data !== 32'd5 || bus.mem_write_enable !== 1'b1 ||
        bus.stall_request !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_recover: data=%h we=%b stall=%b, required 00000005 1 0",
               bus.mem_write_data, bus.mem_write_enable, bus.stall_request);
    end
    hilo_seen = 0;
    repeat (40) begin
      @(negedge clock);
      #1;
      if (bus.mem_hilo_write_enable === 1'b1 || bus.stall_request === 1'b1) hilo_seen++;
    end
    compared++;
    if (hilo_seen != 0) begin
      mismatched++;
      $display("FAIL reset_residual: %0d cycles with hilo_we/stall, required 0", hilo_seen);
    end
    drive_nop();
  endtask

  initial begin
    drive_nop();
    test_reset();
    test_alu();
    test_div();
    test_back_to_back();
    test_annul();
    test_reset_mid_divide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
